gcd_job_queue: RTL

GCD_JOB_QUEUE -- requirements
Module: gcd_job_queue

---
 rtl/gcd_job_queue_if.sv | 35 +++
 rtl/gcd_job_queue.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/gcd_job_queue_if.sv
// gcd_job_queue_if
//   Bundles the memory-mapped bus, the GCD engine handshake and the
//   interrupt line of gcd_job_queue.
//   slave  : the queue side (gcd_job_queue itself)
//   master : the side driving the bus and modelling the engine
//   Signals:
//     saddress[15:0], srd, swr, sdata_in[31:0] -> bus request into the queue
//     sdata_out[31:0]                          <- registered bus read data
//     gcd_start, gcd_a[31:0], gcd_b[31:0]      <- job launch to the engine
//     gcd_busy, gcd_done, gcd_w[31:0]          -> engine status / result
//     irq                                      <- result FIFO non-empty
interface gcd_job_queue_if;
    logic [15:0] saddress;
    logic        srd;
    logic        swr;
    logic [31:0] sdata_in;
    logic [31:0] sdata_out;
    logic        gcd_start;
    logic [31:0] gcd_a;
    logic [31:0] gcd_b;
    logic        gcd_busy;
    logic        gcd_done;
    logic [31:0] gcd_w;
    logic        irq;

    modport slave (
        input  saddress, srd, swr, sdata_in, gcd_busy, gcd_done, gcd_w,
        output sdata_out, gcd_start, gcd_a, gcd_b, irq
    );

    modport master (
        output saddress, srd, swr, sdata_in, gcd_busy, gcd_done, gcd_w,
        input  sdata_out, gcd_start, gcd_a, gcd_b, irq
    );
endinterface

// File: rtl/gcd_job_queue.sv
// gcd_job_queue
//   Bus-programmed job queue in front of a GCD engine. Operand pairs are
//   written through A1/A2 staging registers into a job FIFO; a small
//   dispatcher launches them on the engine and collects results into a
//   result FIFO read back over the bus.
//   Register map (saddress):
//     0x0F8 A1 staging (R/W)
//     0x0FC A2: write pushes {A1, data}; read returns last A2
//     0x100 result: read pops result FIFO (0 + sticky UNF when empty)
//     0x104 status (R), W1C on bits 8 (OVF) and 9 (UNF)
//   Ports:
//     clk   - clock, rising edge
//     reset - asynchronous, active-high
//     bus   - gcd_job_queue_if.slave (bus, engine handshake, irq)
module gcd_job_queue #(
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    gcd_job_queue_if.slave  bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    localparam logic [15:0] ADDR_A1     = 16'h00F8;
    localparam logic [15:0] ADDR_A2     = 16'h00FC;
    localparam logic [15:0] ADDR_RESULT = 16'h0100;
    localparam logic [15:0] ADDR_STATUS = 16'h0104;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    state_t          state_q;
    logic            gcd_start_q;
    logic [31:0]     gcd_a_q, gcd_b_q;
    logic [31:0]     a1_q, a2_q;
    logic [31:0]     sdata_q;
    logic            ovf_q, unf_q, ovf_d, unf_d;

    logic [31:0]     job_a_q [DEPTH];
    logic [31:0]     job_b_q [DEPTH];
    logic [31:0]     res_q   [DEPTH];

    // pointers carry one extra wrap bit so full and empty differ
    logic [PW-1:0]   job_wp_q, job_rp_q, res_wp_q, res_rp_q;
    logic [PW-1:0]   job_wp_d, job_rp_d, res_wp_d, res_rp_d;

    // ------------------------------------------------------------------
    // FIFO status
    // ------------------------------------------------------------------
    logic [PW-1:0]   job_cnt, res_cnt;
    logic            job_full, job_empty, res_full, res_empty;
    logic [31:0]     job_head_a, job_head_b, res_head;

    assign job_cnt    = job_wp_q - job_rp_q;
    assign res_cnt    = res_wp_q - res_rp_q;
    assign job_full   = (job_cnt == PW'(DEPTH));
    assign job_empty  = (job_cnt == '0);
    assign res_full   = (res_cnt == PW'(DEPTH));
    assign res_empty  = (res_cnt == '0);
    assign job_head_a = job_a_q[job_rp_q[AW-1:0]];
    assign job_head_b = job_b_q[job_rp_q[AW-1:0]];
    assign res_head   = res_q[res_rp_q[AW-1:0]];

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic wr_a1, wr_a2, wr_stat, rd_res;
    logic job_push, res_pop, ovf_set, unf_set;

    assign wr_a1    = bus.swr && (bus.saddress == ADDR_A1);
    assign wr_a2    = bus.swr && (bus.saddress == ADDR_A2);
    assign wr_stat  = bus.swr && (bus.saddress == ADDR_STATUS);
    assign rd_res   = bus.srd && (bus.saddress == ADDR_RESULT);

    assign job_push = wr_a2 && !job_full;
    assign ovf_set  = wr_a2 && job_full;
    assign res_pop  = rd_res && !res_empty;
    assign unf_set  = rd_res && res_empty;

    // ------------------------------------------------------------------
    // Dispatcher side of the FIFOs
    // ------------------------------------------------------------------
    // A result slot is reserved for every job that leaves IDLE, so the
    // engine's answer always has a place to land.
    logic            inflight, res_space, head_zero, zero_take, can_issue;
    logic            job_pop, res_push;
    logic [31:0]     res_wdata;
    logic [PW:0]     res_commit;

    assign inflight   = (state_q != S_IDLE);
    assign res_commit = {1'b0, res_cnt} + (PW+1)'(inflight);
    assign res_space  = (res_commit < (PW+1)'(DEPTH));
    assign head_zero  = (job_head_a == '0) || (job_head_b == '0);

    // zero-operand jobs bypass the engine: gcd(x,0) = x, gcd(0,0) = 0
    assign zero_take  = (state_q == S_IDLE) && !job_empty && res_space && head_zero;
    assign can_issue  = (state_q == S_IDLE) && !job_empty && res_space && !head_zero
                        && !bus.gcd_busy;

    assign job_pop    = (state_q == S_ISSUE) || zero_take;
    assign res_push   = zero_take || ((state_q == S_WAIT) && bus.gcd_done);
    assign res_wdata  = zero_take ? ((job_head_a == '0) ? job_head_b : job_head_a)
                                  : bus.gcd_w;

    // ------------------------------------------------------------------
    // Status word and read mux
    // ------------------------------------------------------------------
    logic [31:0] status, rdata;

    assign status = {12'b0, 4'(res_cnt), 4'(job_cnt), 2'b0, unf_q, ovf_q,
                     4'b0, inflight, res_full, job_empty, job_full};

    always_comb begin
        rdata = '0;
        case (bus.saddress)
            ADDR_A1:     rdata = a1_q;
            ADDR_A2:     rdata = a2_q;
            ADDR_RESULT: rdata = res_empty ? '0 : res_head;
            ADDR_STATUS: rdata = status;
            default:     rdata = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Next state for pointers and sticky flags
    // ------------------------------------------------------------------
    always_comb begin
        job_wp_d = job_wp_q + (job_push ? PW'(1) : PW'(0));
        job_rp_d = job_rp_q + (job_pop  ? PW'(1) : PW'(0));
        res_wp_d = res_wp_q + (res_push ? PW'(1) : PW'(0));
        res_rp_d = res_rp_q + (res_pop  ? PW'(1) : PW'(0));
        // a set in the same cycle as a W1C wins
        ovf_d    = ovf_set || (ovf_q && !(wr_stat && bus.sdata_in[8]));
        unf_d    = unf_set || (unf_q && !(wr_stat && bus.sdata_in[9]));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            job_wp_q <= '0;
            job_rp_q <= '0;
            res_wp_q <= '0;
            res_rp_q <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            a1_q     <= '0;
            a2_q     <= '0;
            sdata_q  <= '0;
        end else begin
            job_wp_q <= job_wp_d;
            job_rp_q <= job_rp_d;
            res_wp_q <= res_wp_d;
            res_rp_q <= res_rp_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            if (wr_a1)   a1_q    <= bus.sdata_in;
            if (wr_a2)   a2_q    <= bus.sdata_in;
            if (bus.srd) sdata_q <= rdata;
        end
    end

    // FIFO payload needs no reset; pointers define what is valid
    always_ff @(posedge clk) begin
        if (job_push) begin
            job_a_q[job_wp_q[AW-1:0]] <= a1_q;
            job_b_q[job_wp_q[AW-1:0]] <= bus.sdata_in;
        end
        if (res_push) res_q[res_wp_q[AW-1:0]] <= res_wdata;
    end

    // ------------------------------------------------------------------
    // Dispatcher FSM
    // ------------------------------------------------------------------
    // gcd_done outside WAIT falls through the default hold: it is ignored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            gcd_start_q <= 1'b0;
            gcd_a_q     <= '0;
            gcd_b_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (can_issue) begin
                        state_q     <= S_ISSUE;
                        gcd_start_q <= 1'b1;
                        gcd_a_q     <= job_head_a;
                        gcd_b_q     <= job_head_b;
                    end
                end
                S_ISSUE: begin
                    gcd_start_q <= 1'b0;
                    state_q     <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.gcd_done) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.gcd_start = gcd_start_q;
    assign bus.gcd_a     = gcd_a_q;
    assign bus.gcd_b     = gcd_b_q;
    assign bus.sdata_out = sdata_q;
    assign bus.irq       = !res_empty;

endmodule
